// File: rtl/edram_pkg.sv
// Shared types and constants for the eDRAM bank controller and its cell model.
// Includes a helper used at elaboration time to reject refresh settings that cannot meet retention.
package edram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACT  = 2'd1,
        PRE  = 2'd2
    } state_e;

    localparam int DEF_ROWS             = 16;
    localparam int DEF_COLS             = 8;
    localparam int DEF_REFRESH_INTERVAL = 100;
    localparam int LEAKAGE_CYCLES       = 2000;

    // A full sweep, with each refresh delayed by at most one in-flight access, must fit inside the leakage window.
    function automatic bit refresh_budget_ok(input int rows, input int interval);
        return (interval >= 4) && (rows > 0) && ((rows & (rows - 1)) == 0)
            && (rows * (interval + 3) < LEAKAGE_CYCLES);
    endfunction

endpackage

// File: rtl/edram_refresh_timer.sv
// Free-running refresh interval counter with a pending flag and the row pointer for the next refresh.
module edram_refresh_timer #(
    parameter int ROWS             = 16,
    parameter int ADDR_W           = $clog2(ROWS),
    parameter int REFRESH_INTERVAL = 100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_ptr_inc,
    output logic              o_pending,
    output logic [ADDR_W-1:0] o_ptr
);

    localparam int CNT_W = $clog2(REFRESH_INTERVAL);

    logic [CNT_W-1:0]  r_cnt;
    logic              r_pending;
    logic [ADDR_W-1:0] r_ptr;
    logic              w_wrap;

    assign w_wrap    = (r_cnt == CNT_W'(REFRESH_INTERVAL - 1));
    assign o_pending = r_pending;
    assign o_ptr     = r_ptr;

    // The counter never pauses; a wrap always wins over a clear, though the interval makes them disjoint.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_ptr     <= '0;
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            if (w_wrap) begin
                r_pending <= 1'b1;
            end else if (i_clr) begin
                r_pending <= 1'b0;
            end
            if (i_ptr_inc) begin
                r_ptr <= r_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/edram_row_ctrl.sv
// Array-side controller for one eDRAM bank: turns host requests and periodic refreshes into
// three-cycle IDLE -> ACT -> PRE sequences on the wordlines, write enable and bitlines.
module edram_row_ctrl
    import edram_pkg::*;
#(
    parameter int ROWS             = DEF_ROWS,
    parameter int COLS             = DEF_COLS,
    parameter int ADDR_W           = $clog2(ROWS),
    parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [COLS-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [COLS-1:0]   rsp_rdata,
    output logic              refresh_busy,
    output logic [ROWS-1:0]   wl,
    output logic              write_en,
    inout  wire  [COLS-1:0]   bl,
    output state_e            o_dbg_state
);

    if (!refresh_budget_ok(ROWS, REFRESH_INTERVAL)) begin : g_bad_cfg
        $error("edram_row_ctrl: ROWS/REFRESH_INTERVAL cannot meet the retention window");
    end

    state_e            r_state;
    logic              r_is_ref;
    logic              r_we;
    logic [COLS-1:0]   r_wdata;
    logic [ROWS-1:0]   r_wl;
    logic              r_write_en;
    logic              r_rsp_valid;
    logic [COLS-1:0]   r_rsp_rdata;
    logic              r_refresh_busy;
    logic              w_ref_pending;
    logic [ADDR_W-1:0] w_ref_ptr;
    logic              w_start_ref;
    logic              w_ptr_inc;
    logic              w_accept;

    edram_refresh_timer #(
        .ROWS             (ROWS),
        .ADDR_W           (ADDR_W),
        .REFRESH_INTERVAL (REFRESH_INTERVAL)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_start_ref),
        .i_ptr_inc (w_ptr_inc),
        .o_pending (w_ref_pending),
        .o_ptr     (w_ref_ptr)
    );

    // Handshake: a request is taken on a rising edge where req_valid && req_ready; req_ready depends only
    // on registered state (and is low while reset is held); rsp_valid is a one-cycle pulse with no backpressure.
    assign req_ready   = rst_n && (r_state == IDLE) && !w_ref_pending;
    assign w_accept    = req_valid && req_ready;
    assign w_start_ref = (r_state == IDLE) && w_ref_pending;
    assign w_ptr_inc   = (r_state == PRE) && r_is_ref;

    assign wl           = r_wl;
    assign write_en     = r_write_en;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rsp_rdata;
    assign refresh_busy = r_refresh_busy;
    assign o_dbg_state  = r_state;
    assign bl           = r_write_en ? r_wdata : {COLS{1'bz}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_is_ref       <= 1'b0;
            r_we           <= 1'b0;
            r_wdata        <= '0;
            r_wl           <= '0;
            r_write_en     <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_rdata    <= '0;
            r_refresh_busy <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_ref_pending) begin
                        r_state        <= ACT;
                        r_is_ref       <= 1'b1;
                        r_we           <= 1'b0;
                        r_wl           <= ROWS'(1) << w_ref_ptr;
                        r_refresh_busy <= 1'b1;
                    end else if (w_accept) begin
                        r_state    <= ACT;
                        r_is_ref   <= 1'b0;
                        r_we       <= req_we;
                        r_wdata    <= req_wdata;
                        r_wl       <= ROWS'(1) << req_addr;
                        r_write_en <= req_we;
                    end
                end
                ACT: begin
                    r_state    <= PRE;
                    r_wl       <= '0;
                    r_write_en <= 1'b0;
                    // The cell has been driving the bitlines for the whole ACT cycle.
                    if (!r_is_ref && !r_we) begin
                        r_rsp_rdata <= bl;
                        r_rsp_valid <= 1'b1;
                    end
                end
                PRE: begin
                    r_state        <= IDLE;
                    r_is_ref       <= 1'b0;
                    r_rsp_valid    <= 1'b0;
                    r_refresh_busy <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_edram_row_ctrl.sv
// Bench for edram_row_ctrl: a leaky cell-array model on the bitlines, a read-response scoreboard and
// scenario tasks for reset, access, retention, refresh priority, pointer wrap and reset mid-write.
`timescale 1ns/1ps
module tb_edram_row_ctrl;
    import edram_pkg::*;

    localparam int ROWS   = 16;
    localparam int COLS   = 8;
    localparam int ADDR_W = 4;
    localparam int RI     = 100;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [COLS-1:0]   req_wdata = '0;
    logic              req_ready;
    logic              rsp_valid;
    logic [COLS-1:0]   rsp_rdata;
    logic              refresh_busy;
    logic [ROWS-1:0]   wl;
    logic              write_en;
    state_e            dbg_state;
    wire  [COLS-1:0]   bl;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [COLS-1:0] exp_q[$];
    int              acc_q[$];
    int              ref_rows[$];
    int              ref_cycs[$];
    logic [COLS-1:0] mon_e;
    int              mon_a;

    // Cell array model: each row leaks to zero once it goes untouched for longer than LEAKAGE_CYCLES.
    logic [COLS-1:0] mem[ROWS] = '{default: '0};
    int              last_t[ROWS] = '{default: 0};
    logic            probe_en = 1'b0;
    logic [COLS-1:0] probe_val = '0;
    logic            cell_drive;
    logic [COLS-1:0] cell_q;
    int              cell_row;

    always #5 clk = ~clk;

    edram_row_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W), .REFRESH_INTERVAL(RI)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .refresh_busy(refresh_busy),
        .wl(wl), .write_en(write_en), .bl(bl), .o_dbg_state(dbg_state)
    );

    function automatic int row_of(input logic [ROWS-1:0] v);
        for (int i = 0; i < ROWS; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    always_comb begin
        cell_row   = row_of(wl);
        cell_drive = (wl != '0) && !write_en;
        cell_q     = ((cyc - last_t[cell_row]) > LEAKAGE_CYCLES) ? '0 : mem[cell_row];
    end

    assign bl = probe_en ? probe_val : (cell_drive ? cell_q : {COLS{1'bz}});

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wl != '0) begin
            mem[cell_row]    <= write_en ? bl : cell_q;
            last_t[cell_row] <= cyc;
        end
    end

    // Response scoreboard, refresh logger and wordline invariant.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_unexpected: rsp_valid=1 rdata=%h, required no response", rsp_rdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_a = acc_q.pop_front();
                    if (rsp_rdata !== mon_e) begin
                        n_fail++;
                        $display("FAIL rsp_rdata: got %h, required %h", rsp_rdata, mon_e);
                    end
                    n_tests++;
                    if (cyc - mon_a != 2) begin
                        n_fail++;
                        $display("FAIL rsp_latency: got %0d cycles, required 2", cyc - mon_a);
                    end
                end
            end
            if (refresh_busy && wl != '0) begin
                ref_rows.push_back(row_of(wl));
                ref_cycs.push_back(cyc);
            end
            n_tests++;
            if (!$onehot0(wl) || (write_en && wl == '0)) begin
                n_fail++;
                $display("FAIL wl_invariant: wl=%h write_en=%b, required wl zero/one-hot and write_en only with wl", wl, write_en);
            end
        end
    end

    task automatic host_access(input logic we, input int addr, input logic [COLS-1:0] d,
                               input logic [COLS-1:0] exp_rd);
        int budget = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = ADDR_W'(addr);
        req_wdata = d;
        while (!req_ready && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        n_tests++;
        if (!req_ready) begin
            n_fail++;
            $display("FAIL accept_timeout: req_ready=%b, required 1 within 10 cycles", req_ready);
            req_valid = 1'b0;
            return;
        end
        if (!we) begin
            exp_q.push_back(exp_rd);
            acc_q.push_back(cyc);
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = ~d;
    endtask

    task automatic drain();
        int b = 0;
        while (exp_q.size() != 0 && b < 20) begin
            @(negedge clk);
            b++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 4'd5;
        req_wdata = 8'hFF;
        probe_en  = 1'b1;
        probe_val = 8'h3C;
        repeat (3) begin
            @(negedge clk);
            n_tests += 4;
            if (wl !== '0) begin n_fail++; $display("FAIL reset_wl: got %h, required 0", wl); end
            if (write_en !== 1'b0) begin n_fail++; $display("FAIL reset_write_en: got %b, required 0", write_en); end
            if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b, required 0", req_ready); end
            if (bl !== 8'h3C) begin n_fail++; $display("FAIL reset_bl_released: got %h, required probe value 3c", bl); end
        end
        n_tests += 3;
        if (rsp_valid !== 1'b0 || rsp_rdata !== '0) begin
            n_fail++; $display("FAIL reset_rsp: valid=%b rdata=%h, required 0/00", rsp_valid, rsp_rdata);
        end
        if (refresh_busy !== 1'b0) begin n_fail++; $display("FAIL reset_refresh_busy: got %b, required 0", refresh_busy); end
        if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d, required IDLE", dbg_state); end
        rst_n     = 1'b1;
        req_valid = 1'b0;
        probe_en  = 1'b0;
        #1;
        n_tests++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL release_req_ready: got %b, required 1", req_ready); end
    endtask

    task automatic test_write_read();
        host_access(1'b1, 5, 8'hA5, '0);
        n_tests += 3;
        if (wl !== 16'h0020) begin n_fail++; $display("FAIL write_act_wl: got %h, required 0020", wl); end
        if (write_en !== 1'b1) begin n_fail++; $display("FAIL write_act_we: got %b, required 1", write_en); end
        if (bl !== 8'hA5) begin n_fail++; $display("FAIL write_act_bl: got %h, required a5", bl); end
        host_access(1'b1, 12, 8'hC3, '0);
        host_access(1'b0, 5, '0, 8'hA5);
        host_access(1'b0, 12, '0, 8'hC3);
        drain();
        n_tests++;
        if (rsp_rdata !== 8'hC3) begin n_fail++; $display("FAIL rdata_hold: got %h, required c3", rsp_rdata); end
    endtask

    task automatic test_retention();
        for (int r = 0; r < ROWS; r++) host_access(1'b1, r, 8'hFF, '0);
        repeat (5000) @(negedge clk);
        for (int r = 0; r < ROWS; r++) host_access(1'b0, r, '0, 8'hFF);
        drain();
        force dut.w_ref_pending = 1'b0;
        for (int r = 0; r < ROWS; r++) host_access(1'b1, r, 8'hFF, '0);
        repeat (2200) @(negedge clk);
        for (int r = 0; r < ROWS; r++) host_access(1'b0, r, '0, 8'h00);
        drain();
        release dut.w_ref_pending;
    endtask

    task automatic test_refresh_vs_req();
        bit found = 0;
        int k = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 4'd3;
        req_wdata = 8'h3C;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (refresh_busy && wl != '0) begin
                found = 1;
                break;
            end
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL refresh_seen: no refresh ACT within 300 cycles, required one");
        end else begin
            n_tests += 3;
            if (req_ready !== 1'b0) begin n_fail++; $display("FAIL refresh_req_ready: got %b, required 0", req_ready); end
            if (write_en !== 1'b0) begin n_fail++; $display("FAIL refresh_write_en: got %b, required 0", write_en); end
            if (!$onehot(wl)) begin n_fail++; $display("FAIL refresh_wl: got %h, required one-hot", wl); end
            while (!req_ready && k < 3) begin
                @(negedge clk);
                k++;
            end
            n_tests++;
            if (req_ready !== 1'b1) begin n_fail++; $display("FAIL host_resume: req_ready=%b after %0d cycles, required 1 within 3", req_ready, k); end
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_pointer_wrap();
        int k;
        repeat (10) @(negedge clk);
        k = ref_rows.size();
        repeat (1750) @(negedge clk);
        n_tests++;
        if (ref_rows.size() - k < 17) begin
            n_fail++;
            $display("FAIL refresh_count: got %0d refreshes, required at least 17", ref_rows.size() - k);
        end
        for (int j = k; j < k + 17 && j < ref_rows.size(); j++) begin
            n_tests++;
            if (ref_rows[j] != j % ROWS) begin
                n_fail++;
                $display("FAIL refresh_row[%0d]: got %0d, required %0d", j, ref_rows[j], j % ROWS);
            end
            if (j > k) begin
                n_tests++;
                if (ref_cycs[j] - ref_cycs[j-1] != RI) begin
                    n_fail++;
                    $display("FAIL refresh_spacing[%0d]: got %0d, required %0d", j, ref_cycs[j] - ref_cycs[j-1], RI);
                end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        host_access(1'b1, 2, 8'h5A, '0);
        host_access(1'b1, 9, 8'hEE, '0);
        n_tests++;
        if (wl !== 16'h0200 || write_en !== 1'b1) begin
            n_fail++; $display("FAIL midwrite_act: wl=%h we=%b, required 0200/1", wl, write_en);
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests += 2;
        if (wl !== '0) begin n_fail++; $display("FAIL midwrite_reset_wl: got %h, required 0", wl); end
        if (write_en !== 1'b0) begin n_fail++; $display("FAIL midwrite_reset_we: got %b, required 0", write_en); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        host_access(1'b0, 2, '0, 8'h5A);
        host_access(1'b0, 3, '0, 8'h3C);
        host_access(1'b0, 9, '0, 8'h00);
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_retention();
        test_refresh_vs_req();
        test_pointer_wrap();
        test_reset_mid_write();
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/edram_row_ctrl.md
Name: edram_row_ctrl

Overview:
- Array-side controller for one eDRAM bank of ROWS x COLS single-bit cells; sits directly upstream of the cell array.
- Drives the one-hot wordlines, the shared write enable and the column bitlines.
- Turns host read/write requests into activate/precharge sequences.
- Schedules periodic per-row refresh so no cell exceeds its 2000-cycle retention window.

Parameters:
ROWS, 16, number of wordlines; must be a power of two
COLS, 8, bitlines per row (word width)
ADDR_W, $clog2(ROWS), row address width
REFRESH_INTERVAL, 100, cycles between successive single-row refreshes; must be >=4 and satisfy ROWS*(REFRESH_INTERVAL+3) < 2000

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  host request present
req_ready  output  1  controller can accept a request this cycle
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  row address
req_wdata  input  COLS  write data
rsp_valid  output  1  one-cycle pulse; rsp_rdata valid (reads only)
rsp_rdata  output  COLS  read data, held until next read response
refresh_busy  output  1  high while a refresh ACT or PRE is in progress
wl  output  ROWS  one-hot wordlines; all-zero when idle
write_en  output  1  array write enable
bl  inout  COLS  column bitlines; driven only during write ACT, else high-Z

Behaviour:
- Reset (async, rst_n low): wl=0, write_en=0, bl released, rsp_valid=0, rsp_rdata=0, refresh_busy=0, state=IDLE, interval counter=0, refresh row pointer=0, ref_pending=0.
- Reset mid-operation: the above applies immediately; the in-flight access is abandoned and no response is produced.
- FSM states: IDLE, ACT, PRE.
  - IDLE->ACT on an accepted request or when ref_pending is set.
  - ACT->PRE unconditionally.
  - PRE->IDLE unconditionally.
  - Each access or refresh therefore takes exactly 3 cycles; no back-to-back ACT.
- req_ready = (state==IDLE) && !ref_pending, computed combinationally from registers only.
  - Acceptance: req_valid && req_ready at a rising edge.
  - req_we, req_addr and req_wdata are captured at acceptance; host inputs may change afterwards.
- ACT cycle:
  - wl[addr]=1, all other wl bits 0.
  - Write: write_en=1 and bl driven with the captured wdata.
  - Read or refresh: write_en=0 and bl high-Z; the cell drives bl and restores its own charge at the closing edge.
- Read capture: bl sampled into rsp_rdata at the edge closing ACT. rsp_valid=1 for the whole PRE cycle.
- Read latency: rsp_valid is high in the second cycle after the acceptance edge.
- Writes produce no response. rsp_valid has no backpressure.
- PRE cycle: wl=0, write_en=0, bl high-Z.
- Refresh timer:
  - Counts every cycle from 0 to REFRESH_INTERVAL-1, then wraps to 0 and sets ref_pending.
  - ref_pending clears on entry to a refresh ACT.
  - Refresh row pointer increments when the refresh PRE ends, wrapping ROWS-1 -> 0.
  - The timer keeps counting while a refresh is outstanding.
- Priority:
  - ref_pending beats req_valid in IDLE.
  - An access already in ACT or PRE always completes before the refresh starts.
  - Maximum refresh delay is 2 cycles.
- Simultaneous events:
  - If ref_pending sets on the same edge a request is accepted, the request proceeds and the refresh follows directly after its PRE.
  - A second wrap while ref_pending is still set cannot occur, given REFRESH_INTERVAL >= 4.
- refresh_busy is high exactly during refresh ACT and refresh PRE.
- Invariant: wl is always zero or one-hot; write_en=1 only together with a non-zero wl.

Decomposition:
- Package edram_pkg:
  - state enum (IDLE, ACT, PRE)
  - default ROWS/COLS
  - LEAKAGE_CYCLES=2000 constant shared with the cell model
  - elaboration check function for the refresh-budget inequality
- Sub-module edram_refresh_timer: interval counter, ref_pending flag and refresh row pointer, with a clear input from the FSM.

Test Plan:
- Reset: hold rst_n low 3 cycles with req_valid=1 -> wl=0, bl=Z, req_ready=0 during reset, req_ready=1 on the first cycle after release.
- Write/read: write row 5 with 8'hA5, then read row 5 -> during write ACT wl=16'h0020, write_en=1, bl=A5; read gives rsp_valid pulse 2 cycles after acceptance with rsp_rdata=8'hA5.
- Retention: write 8'hFF to all 16 rows, idle 5000 cycles, read all rows -> all return 8'hFF; with refresh disabled via force, reads return 8'h00.
- Refresh vs request: hold req_valid=1 continuously at the cycle ref_pending sets -> req_ready=0, refresh ACT on the pointer row with refresh_busy=1, and host access resumes within 3 cycles.
- Pointer wrap: observe 17 refreshes -> rows 0..15, then 0; successive refresh ACTs spaced exactly 100 cycles apart when idle.
- Reset mid-write: assert rst_n low during write ACT -> wl and write_en drop immediately; later reads of untouched rows are unaffected.
